// File: rtl/caliptra_fpga_sync_mbox.sv
// rtl/caliptra_fpga_sync_mbox.sv - AXI4-Lite slave feeding NUM_CH host-to-hardware FIFOs
// Per-channel DATA/STATUS/CTRL registers, valid/ready drain ports, sticky overflow irq.
module caliptra_fpga_sync_mbox #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic [2:0]                 awprot,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic [2:0]                 arprot,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic                       irq
);

  localparam int SW   = DATA_W / 8;
  localparam int B    = $clog2(SW);
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CHW:0]    NCH      = (CHW + 1)'(NUM_CH);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Everything above the channel field must be zero and the channel must exist.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [CHW-1:0] c;
    c = a[B+2 +: CHW];
    return ((a >> (B + 2 + CHW)) == '0) && ({1'b0, c} < NCH);
  endfunction

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0]     wp  [NUM_CH];
  logic [PW-1:0]     rp  [NUM_CH];
  logic [CNTW-1:0]   cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] pop;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] flush;
  logic [NUM_CH-1:0] set_ovf;
  logic [NUM_CH-1:0] clr_ovf;

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [SW-1:0]     w_strb_q;
  logic              aw_hs;
  logic              w_hs;
  logic              exec;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [SW-1:0]     ws;
  logic              w_ok;
  logic [1:0]        w_reg;
  logic [CHW-1:0]    w_ch;
  logic [1:0]        bresp_n;

  logic              r_ok;
  logic [1:0]        r_reg;
  logic [CHW-1:0]    r_ch;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        rresp_n;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, wa[B-1:0], araddr[B-1:0]};

  assign awready = ~aw_held;
  assign wready  = ~w_held;
  assign arready = ~rvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // A beat accepted this cycle counts as held, so the write can execute on the handshake edge.
  assign wa   = aw_held ? aw_addr_q : awaddr;
  assign wd   = w_held  ? w_data_q  : wdata;
  assign ws   = w_held  ? w_strb_q  : wstrb;
  assign exec = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;

  assign w_ok  = addr_ok(wa);
  assign w_reg = wa[B+1:B];
  assign w_ch  = wa[B+2 +: CHW];

  assign r_ok  = addr_ok(araddr);
  assign r_reg = araddr[B+1:B];
  assign r_ch  = araddr[B+2 +: CHW];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]     = (cnt[c] == FULL_CNT);
      ch_valid[c] = (cnt[c] != '0);
      pop[c]      = ch_valid[c] & ch_ready[c];
    end
  end

  always_comb begin
    ch_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_valid[c]) ch_data[c*DATA_W +: DATA_W] = mem[c][rp[c]];
    end
  end

  assign irq = |ovf;

  always_comb begin
    push    = '0;
    flush   = '0;
    set_ovf = '0;
    clr_ovf = '0;
    bresp_n = OKAY;
    if (exec) begin
      if (!w_ok) begin
        bresp_n = DECERR;
      end else begin
        case (w_reg)
          2'd0: begin
            if (ws != '1) begin
              bresp_n = SLVERR;
            end else if (full[w_ch]) begin
              bresp_n       = SLVERR;
              set_ovf[w_ch] = 1'b1;
            end else begin
              push[w_ch] = 1'b1;
            end
          end
          2'd1:    clr_ovf[w_ch] = wd[18];
          2'd2:    flush[w_ch]   = wd[0];
          default: bresp_n       = DECERR;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (exec) begin
        bvalid <= 1'b1;
        bresp  <= bresp_n;
      end else if (bvalid && bready) begin
        bvalid  <= 1'b0;
        bresp   <= OKAY;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wp[c]] <= wd;
    end
  end

  // Flush beats a same-cycle pop; the full check above ignores any pop.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wp[c]  <= '0;
        rp[c]  <= '0;
        cnt[c] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          wp[c]  <= '0;
          rp[c]  <= '0;
          cnt[c] <= '0;
        end else begin
          if (push[c]) wp[c] <= wp[c] + 1'b1;
          if (pop[c])  rp[c] <= rp[c] + 1'b1;
          case ({push[c], pop[c]})
            2'b10:   cnt[c] <= cnt[c] + 1'b1;
            2'b01:   cnt[c] <= cnt[c] - 1'b1;
            default: cnt[c] <= cnt[c];
          endcase
        end
        if (set_ovf[c])      ovf[c] <= 1'b1;
        else if (clr_ovf[c]) ovf[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_n = '0;
    rresp_n = OKAY;
    if (!r_ok || r_reg == 2'd3) begin
      rresp_n = DECERR;
    end else if (r_reg == 2'd1) begin
      rdata_n[15:0] = 16'(cnt[r_ch]);
      rdata_n[16]   = (cnt[r_ch] == '0);
      rdata_n[17]   = (cnt[r_ch] == FULL_CNT);
      rdata_n[18]   = ovf[r_ch];
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rdata_n;
      rresp  <= rresp_n;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_sync_mbox.sv
// tb/tb_caliptra_fpga_sync_mbox.sv - self-checking bench for caliptra_fpga_sync_mbox
// Expected responses are queued when stimulus is driven and popped when the DUT responds.
module tb_caliptra_fpga_sync_mbox;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;

  logic                     aclk = 1'b0;
  logic                     rst  = 1'b1;
  logic                     awvalid = 1'b0, awready;
  logic [ADDR_W-1:0]        awaddr  = '0;
  logic [2:0]               awprot  = '0;
  logic                     wvalid  = 1'b0, wready;
  logic [DATA_W-1:0]        wdata   = '0;
  logic [DATA_W/8-1:0]      wstrb   = '0;
  logic                     bvalid, bready = 1'b0;
  logic [1:0]               bresp;
  logic                     arvalid = 1'b0, arready;
  logic [ADDR_W-1:0]        araddr  = '0;
  logic [2:0]               arprot  = '0;
  logic                     rvalid, rready = 1'b0;
  logic [DATA_W-1:0]        rdata;
  logic [1:0]               rresp;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready = '0;
  logic                     irq;

  int checks = 0;
  int errors = 0;

  logic [1:0]        exp_b[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [1:0]        exp_rr[$];
  logic [63:0]       q0[$];
  logic [63:0]       q2[$];

  caliptra_fpga_sync_mbox #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready), .irq(irq)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] st(input int cnt, input bit empty, input bit full, input bit ov);
    logic [63:0] v;
    v = '0;
    v[15:0] = 16'(cnt);
    v[16]   = empty;
    v[17]   = full;
    v[18]   = ov;
    return v;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                    input logic [1:0] er, input logic [3:0] popm, output int lat);
    int n;
    logic [1:0] eb;
    exp_b.push_back(er);
    @(negedge aclk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; ch_ready = popm;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; ch_ready = '0; bready = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!bvalid && n < 20);
    lat = n;
    eb = exp_b.pop_front();
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL wr_timeout addr=%h: bvalid never rose", a);
    end else if (bresp !== eb) begin
      errors++;
      $display("FAIL wr_bresp addr=%h: got %b expected %b", a, bresp, eb);
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] ed, input logic [1:0] er);
    int n;
    logic [63:0] xd;
    logic [1:0]  xr;
    exp_rd.push_back(ed);
    exp_rr.push_back(er);
    @(negedge aclk);
    arvalid = 1'b1; araddr = a;
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!rvalid && n < 20);
    xd = exp_rd.pop_front();
    xr = exp_rr.pop_front();
    checks++;
    if (!rvalid) begin
      errors++;
      $display("FAIL rd_timeout addr=%h: rvalid never rose", a);
    end else if (rdata !== xd || rresp !== xr) begin
      errors++;
      $display("FAIL rd addr=%h: got data=%h resp=%b expected data=%h resp=%b", a, rdata, rresp, xd, xr);
    end
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic pop_ch(input int c, input logic [63:0] ed);
    @(negedge aclk);
    checks++;
    if (ch_valid[c] !== 1'b1 || ch_data[c*DATA_W +: DATA_W] !== ed) begin
      errors++;
      $display("FAIL pop ch%0d: got valid=%b data=%h expected valid=1 data=%h",
               c, ch_valid[c], ch_data[c*DATA_W +: DATA_W], ed);
    end
    ch_ready[c] = 1'b1;
    @(posedge aclk); #1;
    ch_ready[c] = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, irq} !== 3'b000 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_resp: got bvalid=%b rvalid=%b irq=%b bresp=%b rresp=%b rdata=%h expected all zero",
               bvalid, rvalid, irq, bresp, rresp, rdata);
    end
    checks++;
    if (ch_valid !== '0 || ch_data !== '0) begin
      errors++;
      $display("FAIL reset_ch: got valid=%b data=%h expected 0", ch_valid, ch_data);
    end
  endtask

  task automatic test_basic();
    int lat;
    wr(32'h20, 64'h1122334455667788, 8'hFF, 2'b00, 4'h0, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected 1", lat);
    end
    checks++;
    if (ch_valid !== 4'b0010 || ch_data[127:64] !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL basic_ch1: got valid=%b data=%h expected valid=0010 data=1122334455667788",
               ch_valid, ch_data[127:64]);
    end
    rd(32'h28, st(1, 0, 0, 0), 2'b00);
    rd(32'h20, 64'h0, 2'b00);
    pop_ch(1, 64'h1122334455667788);
    rd(32'h28, st(0, 1, 0, 0), 2'b00);
  endtask

  task automatic test_overflow();
    int lat;
    logic [63:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = {$urandom, $urandom};
      q0.push_back(d);
      wr(32'h00, d, 8'hFF, 2'b00, 4'h0, lat);
    end
    wr(32'h00, 64'hDEAD_BEEF_0000_0009, 8'hFF, 2'b10, 4'h0, lat);
    rd(32'h08, st(DEPTH, 0, 1, 1), 2'b00);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL ovf_irq_set: got %b expected 1", irq);
    end
    wr(32'h08, 64'h1 << 18, 8'hFF, 2'b00, 4'h0, lat);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ovf_irq_clr: got %b expected 0", irq);
    end
    rd(32'h08, st(DEPTH, 0, 1, 0), 2'b00);
    checks++;
    if (ch_data[63:0] !== q0[0]) begin
      errors++;
      $display("FAIL ovf_head: got %h expected %h", ch_data[63:0], q0[0]);
    end
    wr(32'h10, 64'h1, 8'hFF, 2'b00, 4'h0, lat);
    q0.delete();
    rd(32'h08, st(0, 1, 0, 0), 2'b00);
  endtask

  task automatic test_stream();
    int lat;
    logic [63:0] d;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      q0.push_back(d);
      wr(32'h00, d, 8'hFF, 2'b00, 4'h0, lat);
    end
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      checks++;
      if (ch_data[63:0] !== q0[0]) begin
        errors++;
        $display("FAIL stream_head%0d: got %h expected %h", i, ch_data[63:0], q0[0]);
      end
      wr(32'h00, d, 8'hFF, 2'b00, 4'h1, lat);
      void'(q0.pop_front());
      q0.push_back(d);
      rd(32'h08, st(3, 0, 0, 0), 2'b00);
    end
    while (q0.size() > 0) pop_ch(0, q0.pop_front());
    rd(32'h08, st(0, 1, 0, 0), 2'b00);
  endtask

  task automatic test_split_aw_w();
    logic [1:0] eb;
    logic [63:0] d;
    d = 64'hA5A5_0000_1234_5678;
    exp_b.push_back(2'b00);
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 32'h40;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL split_c1: got awready=%b wready=%b bvalid=%b expected 0 1 0", awready, wready, bvalid);
    end
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL split_c2: got bvalid=%b expected 0", bvalid);
    end
    @(negedge aclk);
    wvalid = 1'b1; wdata = d; wstrb = 8'hFF;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    q2.push_back(d);
    @(negedge aclk);
    eb = exp_b.pop_front();
    checks++;
    if (bvalid !== 1'b1 || bresp !== eb) begin
      errors++;
      $display("FAIL split_c4: got bvalid=%b bresp=%b expected 1 %b", bvalid, bresp, eb);
    end
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
      errors++;
      $display("FAIL split_c5: got bvalid=%b awready=%b wready=%b expected 1 0 0", bvalid, awready, wready);
    end
    @(negedge aclk);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL split_after_b: got bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
    end
    rd(32'h48, st(1, 0, 0, 0), 2'b00);
  endtask

  task automatic test_errors();
    int lat;
    rd(32'h18, 64'h0, 2'b11);
    wr(32'h18, 64'h1, 8'hFF, 2'b11, 4'h0, lat);
    wr(32'h80, 64'h2, 8'hFF, 2'b11, 4'h0, lat);
    rd(32'h88, 64'h0, 2'b11);
    wr(32'h00, 64'h3, 8'h0F, 2'b10, 4'h0, lat);
    rd(32'h08, st(0, 1, 0, 0), 2'b00);
    rd(32'h48, st(1, 0, 0, 0), 2'b00);
    checks++;
    if (ch_valid !== 4'b0100 || irq !== 1'b0) begin
      errors++;
      $display("FAIL err_no_change: got valid=%b irq=%b expected 0100 0", ch_valid, irq);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] d;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      q2.push_back(d);
      wr(32'h40, d, 8'hFF, 2'b00, 4'h0, lat);
    end
    rd(32'h48, st(DEPTH / 2, 0, 0, 0), 2'b00);
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 32'h60; wvalid = 1'b1; wdata = 64'h77; wstrb = 8'hFF;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got bvalid=%b expected 1", bvalid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bvalid !== 1'b0 || ch_valid !== '0 || arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: got bvalid=%b ch_valid=%b arready=%b awready=%b wready=%b expected 0 0000 1 1 1",
               bvalid, ch_valid, arready, awready, wready);
    end
    @(negedge aclk);
    rst = 1'b0;
    q2.delete();
    rd(32'h48, st(0, 1, 0, 0), 2'b00);
    rd(32'h68, st(0, 1, 0, 0), 2'b00);
    repeat (3) @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_resp: got bvalid=%b expected 0", bvalid);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge aclk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stream();
    test_split_aw_w();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
